// File: rtl/load_unit_pkg.sv
// load_unit_pkg: load opcodes, FSM states and opcode decode helpers shared by the load unit
package load_unit_pkg;
  localparam logic [5:0] ALU_LB  = 6'd10;
  localparam logic [5:0] ALU_LH  = 6'd11;
  localparam logic [5:0] ALU_LW  = 6'd12;
  localparam logic [5:0] ALU_LBU = 6'd13;
  localparam logic [5:0] ALU_LHU = 6'd14;
  localparam logic [5:0] ALU_LWU = 6'd15;
  localparam logic [5:0] ALU_LD  = 6'd16;
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_DONE
  } state_t;
  function automatic logic [3:0] load_size(input logic [5:0] code, input int xlen);
    return (code == ALU_LB || code == ALU_LBU) ? 4'd1 :
           (code == ALU_LH || code == ALU_LHU) ? 4'd2 :
           (code == ALU_LW)                    ? 4'd4 :
           (xlen == 64 && code == ALU_LWU)     ? 4'd4 :
           (xlen == 64 && code == ALU_LD)      ? 4'd8 : 4'd0;
  endfunction
  function automatic logic load_signed(input logic [5:0] code);
    return code == ALU_LB || code == ALU_LH || code == ALU_LW || code == ALU_LD;
  endfunction
endpackage

// File: rtl/load_extract.sv
// load_extract: selects the addressed bytes from a two-word pair and sign/zero-extends them
module load_extract
  import load_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]          pair,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [5:0]                 alucode,
  output logic [XLEN-1:0]            result
);
  localparam int AW = $clog2(XLEN);
  logic [XLEN-1:0] sh, keep;
  logic [6:0] nbits;
  logic [AW-1:0] top;
  logic sgn;
  always_comb begin
    sh = XLEN'(pair >> {off, 3'b000});
    nbits = {load_size(alucode, XLEN), 3'b000};
    top = AW'(nbits - 7'd1);
    keep = nbits >= 7'(XLEN) ? '1 : (XLEN'(1) << nbits) - XLEN'(1);
    sgn = load_signed(alucode) & sh[top];
    result = (sh & keep) | (sgn ? ~keep : '0);
  end
endmodule

// File: rtl/load_unit.sv
// load_unit: one-at-a-time load FSM issuing one or two aligned reads and returning an extended result
module load_unit
  import load_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [5:0]      req_alucode,
  input  logic [XLEN-1:0] req_addr,
  input  logic [4:0]      req_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_fault
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  state_t state, nxt;
  logic [5:0] code_q;
  logic [XLEN-1:0] addr_q, w0, w1, aligned, ext;
  logic [4:0] rd_q;
  logic fault_q, split_q, req_split, req_bad;
  logic [3:0] req_size;
  assign req_size = load_size(req_alucode, XLEN);
  assign req_split = int'(req_addr[OW-1:0]) + int'(req_size) > NB;
  assign req_bad = req_size == 4'd0 || (req_split && !ALLOW_MISALIGNED);
  assign aligned = {addr_q[XLEN-1:OW], {OW{1'b0}}};
  load_extract #(.XLEN(XLEN)) u_extract (
    .pair    ({w1, w0}),
    .off     (addr_q[OW-1:0]),
    .alucode (code_q),
    .result  (ext)
  );
  always_comb begin
    nxt = state;
    req_ready = rst_n && state == S_IDLE;
    mem_req_valid = state == S_REQ0 || state == S_REQ1;
    mem_addr = state == S_REQ0 ? aligned : state == S_REQ1 ? aligned + XLEN'(NB) : '0;
    wb_valid = state == S_DONE;
    wb_rd = state == S_DONE ? rd_q : '0;
    wb_fault = state == S_DONE && fault_q;
    wb_data = (state == S_DONE && !fault_q) ? ext : '0;
    case (state)
      S_IDLE:  if (req_valid) nxt = req_bad ? S_DONE : S_REQ0;
      S_REQ0:  if (mem_req_ready) nxt = S_WAIT0;
      S_WAIT0: if (mem_rsp_valid) nxt = split_q ? S_REQ1 : S_DONE;
      S_REQ1:  if (mem_req_ready) nxt = S_WAIT1;
      S_WAIT1: if (mem_rsp_valid) nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      code_q <= '0;
      addr_q <= '0;
      rd_q <= '0;
      w0 <= '0;
      w1 <= '0;
      fault_q <= 1'b0;
      split_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && req_valid) begin
        code_q <= req_alucode;
        addr_q <= req_addr;
        rd_q <= req_rd;
        fault_q <= req_bad;
        split_q <= req_split;
      end
      if (state == S_WAIT0 && mem_rsp_valid) w0 <= mem_rdata;
      if (state == S_WAIT1 && mem_rsp_valid) w1 <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: scoreboard bench driving three load_unit configurations through directed loads
module tb_load_unit;
  import load_unit_pkg::*;
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        fault;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, rv_a, rv_b, rv_c, mrr, mrsp;
  logic [5:0] code;
  logic [63:0] addr, rdata;
  logic [4:0] rd;
  logic a_rr, a_mrv, a_wbv, a_wbf, b_rr, b_mrv, b_wbv, b_wbf, c_rr, c_mrv, c_wbv, c_wbf;
  logic [31:0] a_ma, a_wbd, b_ma, b_wbd;
  logic [63:0] c_ma, c_wbd;
  logic [4:0] a_wbrd, b_wbrd, c_wbrd;
  int sel = 0;
  logic o_rr, o_mrv, o_wbv, o_wbf;
  logic [63:0] o_ma, o_wbd;
  logic [4:0] o_wbrd;
  exp_t sb[$];
  logic [63:0] aq[$];
  int n_assert = 0, n_fail = 0;
  load_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_a), .req_ready(a_rr), .req_alucode(code),
    .req_addr(addr[31:0]), .req_rd(rd), .mem_req_valid(a_mrv), .mem_req_ready(mrr),
    .mem_addr(a_ma), .mem_rsp_valid(mrsp), .mem_rdata(rdata[31:0]), .wb_valid(a_wbv),
    .wb_rd(a_wbrd), .wb_data(a_wbd), .wb_fault(a_wbf)
  );
  load_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_b), .req_ready(b_rr), .req_alucode(code),
    .req_addr(addr[31:0]), .req_rd(rd), .mem_req_valid(b_mrv), .mem_req_ready(mrr),
    .mem_addr(b_ma), .mem_rsp_valid(mrsp), .mem_rdata(rdata[31:0]), .wb_valid(b_wbv),
    .wb_rd(b_wbrd), .wb_data(b_wbd), .wb_fault(b_wbf)
  );
  load_unit #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_c), .req_ready(c_rr), .req_alucode(code),
    .req_addr(addr), .req_rd(rd), .mem_req_valid(c_mrv), .mem_req_ready(mrr),
    .mem_addr(c_ma), .mem_rsp_valid(mrsp), .mem_rdata(rdata), .wb_valid(c_wbv),
    .wb_rd(c_wbrd), .wb_data(c_wbd), .wb_fault(c_wbf)
  );
  always_comb begin
    o_rr   = sel == 2 ? c_rr   : sel == 1 ? b_rr   : a_rr;
    o_mrv  = sel == 2 ? c_mrv  : sel == 1 ? b_mrv  : a_mrv;
    o_wbv  = sel == 2 ? c_wbv  : sel == 1 ? b_wbv  : a_wbv;
    o_wbf  = sel == 2 ? c_wbf  : sel == 1 ? b_wbf  : a_wbf;
    o_wbrd = sel == 2 ? c_wbrd : sel == 1 ? b_wbrd : a_wbrd;
    o_ma   = sel == 2 ? c_ma   : sel == 1 ? {32'd0, b_ma}  : {32'd0, a_ma};
    o_wbd  = sel == 2 ? c_wbd  : sel == 1 ? {32'd0, b_wbd} : {32'd0, a_wbd};
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_rv(input int s, input logic v);
    rv_a = s == 0 && v;
    rv_b = s == 1 && v;
    rv_c = s == 2 && v;
  endtask
  task automatic run_load(input int s, input logic [5:0] c, input logic [63:0] a, input logic [4:0] r,
                          input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] a0,
                          input logic [63:0] a1, input int nr, input logic [63:0] d, input logic f,
                          input int lat, input int stall);
    exp_t e;
    int nreq = 0;
    int st = stall;
    logic pending = 1'b0;
    logic done = 1'b0;
    sel = s;
    sb.push_back('{r, d, f});
    if (nr > 0) aq.push_back(a0);
    if (nr > 1) aq.push_back(a1);
    @(negedge clk);
    chk("req_ready_idle", o_rr, 1);
    code = c;
    addr = a;
    rd = r;
    mrr = 1'b0;
    set_rv(s, 1'b1);
    for (int cy = 0; cy < 40 && !done; cy++) begin
      @(negedge clk);
      set_rv(s, 1'b0);
      mrsp = 1'b0;
      rdata = 64'hDEAD_BEEF_CAFE_F00D;
      if (pending) begin
        mrsp = 1'b1;
        rdata = nreq == 1 ? w0 : w1;
        pending = 1'b0;
      end
      if (o_mrv) begin
        if (aq.size() == 0) chk("spurious_mem_req", o_mrv, 0);
        else begin
          chk("mem_addr", o_ma, aq[0]);
          if (st > 0) begin
            st--;
            mrr = 1'b0;
            chk("wb_during_stall", o_wbv, 0);
          end else begin
            mrr = 1'b1;
            void'(aq.pop_front());
            pending = 1'b1;
            nreq++;
          end
        end
      end else mrr = 1'b0;
      if (o_wbv) begin
        if (sb.size() == 0) chk("spurious_wb", o_wbv, 0);
        else begin
          e = sb.pop_front();
          chk("wb_rd", o_wbrd, e.rd);
          chk("wb_data", o_wbd, e.data);
          chk("wb_fault", o_wbf, e.fault);
          chk("wb_latency", cy, lat);
        end
        done = 1'b1;
      end
    end
    chk("wb_seen", done, 1);
    chk("mem_req_count", nreq, nr);
    @(negedge clk);
    mrsp = 1'b0;
    mrr = 1'b0;
    chk("wb_single_pulse", o_wbv, 0);
    chk("req_ready_again", o_rr, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    set_rv(0, 1'b0);
    mrr = 1'b0;
    mrsp = 1'b0;
    code = '0;
    addr = '0;
    rd = '0;
    rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_a_ready", a_rr, 0);
    chk("rst_a_mrv", a_mrv, 0);
    chk("rst_a_wbv", a_wbv, 0);
    chk("rst_a_wbf", a_wbf, 0);
    chk("rst_a_wbd", a_wbd, 0);
    chk("rst_a_wbrd", a_wbrd, 0);
    chk("rst_c_wbd", c_wbd, 0);
    chk("rst_c_ready", c_rr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", a_rr, 1);
    run_load(0, ALU_LB,  64'h103, 5'd1, 64'h80FF_1234, 0, 64'h100, 0, 1, 64'hFFFF_FF80, 0, 2, 0);
    run_load(0, ALU_LHU, 64'h102, 5'd2, 64'hBEEF_0000, 0, 64'h100, 0, 1, 64'h0000_BEEF, 0, 2, 0);
    run_load(0, ALU_LH,  64'h102, 5'd3, 64'hBEEF_0000, 0, 64'h100, 0, 1, 64'hFFFF_BEEF, 0, 2, 0);
    run_load(0, ALU_LBU, 64'h101, 5'd4, 64'h0000_8000, 0, 64'h100, 0, 1, 64'h0000_0080, 0, 2, 0);
    run_load(0, ALU_LW,  64'h0FE, 5'd5, 64'hAABB_CCDD, 64'h1122_3344, 64'h0FC, 64'h100, 2,
             64'h3344_AABB, 0, 4, 0);
    run_load(0, ALU_LW,  64'hFFFF_FFFE, 5'd6, 64'h5566_7788, 64'h99AA_BBCC, 64'hFFFF_FFFC, 64'h0, 2,
             64'hBBCC_5566, 0, 4, 0);
    run_load(0, ALU_LH,  64'h103, 5'd7, 64'h1200_0000, 64'h0000_00F4, 64'h100, 64'h104, 2,
             64'hFFFF_F412, 0, 4, 0);
    run_load(0, ALU_LD,  64'h100, 5'd8, 0, 0, 0, 0, 0, 64'h0, 1, 0, 0);
    run_load(0, 6'd0,    64'h100, 5'd9, 0, 0, 0, 0, 0, 64'h0, 1, 0, 0);
    run_load(0, ALU_LW,  64'h200, 5'd10, 64'h7654_3210, 0, 64'h200, 0, 1, 64'h7654_3210, 0, 7, 5);
    run_load(1, ALU_LW,  64'h0FE, 5'd11, 0, 0, 0, 0, 0, 64'h0, 1, 0, 0);
    run_load(1, ALU_LW,  64'h100, 5'd12, 64'hCAFE_BABE, 0, 64'h100, 0, 1, 64'hCAFE_BABE, 0, 2, 0);
    run_load(2, ALU_LD,  64'h8, 5'd13, 64'h0123_4567_89AB_CDEF, 0, 64'h8, 0, 1,
             64'h0123_4567_89AB_CDEF, 0, 2, 0);
    run_load(2, ALU_LWU, 64'hC, 5'd14, 64'h0123_4567_89AB_CDEF, 0, 64'h8, 0, 1,
             64'h0000_0000_0123_4567, 0, 2, 0);
    run_load(2, ALU_LW,  64'hC, 5'd15, 64'h89AB_CDEF_0000_0000, 0, 64'h8, 0, 1,
             64'hFFFF_FFFF_89AB_CDEF, 0, 2, 0);
    run_load(2, ALU_LH,  64'hF, 5'd16, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00CD, 64'h8, 64'h10, 2,
             64'hFFFF_FFFF_FFFF_CDAB, 0, 4, 0);
    sel = 0;
    @(negedge clk);
    code = ALU_LW;
    addr = 64'h300;
    rd = 5'd20;
    rv_a = 1'b1;
    mrr = 1'b0;
    @(negedge clk);
    rv_a = 1'b0;
    chk("rst_case_mrv", o_mrv, 1);
    mrr = 1'b1;
    @(negedge clk);
    chk("rst_case_wait0", o_mrv, 0);
    mrr = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", o_rr, 0);
    chk("midrst_wbv", o_wbv, 0);
    chk("midrst_mrv", o_mrv, 0);
    chk("midrst_wbd", o_wbd, 0);
    chk("midrst_wbrd", o_wbrd, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_back", o_rr, 1);
    mrsp = 1'b1;
    rdata = 64'h1357_9BDF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mrsp = 1'b0;
      chk("stray_rsp_wbv", o_wbv, 0);
      chk("stray_rsp_ready", o_rr, 1);
    end
    run_load(0, ALU_LB, 64'h400, 5'd21, 64'h0000_007F, 0, 64'h400, 0, 1, 64'h0000_007F, 0, 2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
